// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator machine sequencer:
//   - opcode constants (IR[7:5])
//   - ALU control codes driven on alu_control
//   - sequencer state encoding
//   - alu_code(): maps an opcode to the ALU control code used in EXEC
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NAND = 3'b001;
   localparam logic [2:0] OP_BRZ  = 3'b010;
   localparam logic [2:0] OP_SLT  = 3'b011;
   localparam logic [2:0] OP_LDA  = 3'b100;
   localparam logic [2:0] OP_STA  = 3'b101;
   localparam logic [2:0] OP_LDI  = 3'b110;
   localparam logic [2:0] OP_HLT  = 3'b111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_NAND = 2'b01;
   localparam logic [1:0] ALU_BRZ  = 2'b10;
   localparam logic [1:0] ALU_SLT  = 2'b11;

   typedef enum logic [2:0] {
      FETCH_OP,
      FETCH_ARG,
      READ_DATA,
      WRITE,
      EXEC,
      HALT
   } seq_state_t;

   // Opcodes that do not use the ALU result map to ALU_ADD (don't care).
   function automatic logic [1:0] alu_code(input logic [2:0] op);
      logic [1:0] code;
      case (op)
         OP_NAND: code = ALU_NAND;
         OP_BRZ:  code = ALU_BRZ;
         OP_SLT:  code = ALU_SLT;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seq_mem_port.sv
// -----------------------------------------------------------------------------
// seq_mem_port
// Registered req/ack memory port for the sequencer. A one-cycle start from
// the FSM latches we/addr/wdata and raises mem_req; the request is held
// stable until mem_ack, and mem_req drops in the cycle after the ack.
// done is the qualified ack (mem_req & mem_ack); an ack with no request
// outstanding is ignored.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, we, addr, wdata        request from the FSM (sampled when idle)
//   done                          completion strobe back to the FSM
//   mem_req/we/addr/wdata/ack     external memory handshake
// -----------------------------------------------------------------------------
module seq_mem_port #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack
);

   assign done = mem_req & mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (mem_req) begin
         if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end
      end else if (start) begin
         mem_req   <= 1'b1;
         mem_we    <= we;
         mem_addr  <= addr;
         mem_wdata <= wdata;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Fetch/decode/execute controller for the 8-bit accumulator machine. Owns
// PC, IR (opcode field), operand register and ACC; fetches two-byte
// instructions through seq_mem_port and writes ALU results back to ACC/PC.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   mem_req/we/addr/wdata/rdata/ack     memory handshake
//   alu_control, alu_acc, alu_data,
//   alu_pc, alu_result                  ALU interface (operands registered)
//   acc_out                             ACC for debug
//   halted                              high while in HALT
//   retire_cnt                          retired-instruction counter, present
//                                       only when CPU_SEQUENCER_RETIRE_CNT_EN
//                                       is defined
// -----------------------------------------------------------------------------
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int              ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [1:0]        alu_control,
   output logic [7:0]        alu_acc,
   output logic [7:0]        alu_data,
   output logic [ADDR_W-1:0] alu_pc,
   input  logic [7:0]        alu_result,
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
   output logic [15:0]       retire_cnt,
`endif
   output logic [7:0]        acc_out,
   output logic              halted
);

   seq_state_t        state, state_next;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        ir_op;
   logic [7:0]        operand;
   logic [7:0]        acc;

   logic              start;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic              done;

   seq_mem_port #(.ADDR_W(ADDR_W)) u_mem_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .we        (req_we),
      .addr      (req_addr),
      .wdata     (acc),
      .done      (done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack)
   );

   assign alu_control = alu_code(ir_op);
   assign alu_acc     = acc;
   assign alu_data    = operand;
   assign alu_pc      = pc;
   assign acc_out     = acc;
   assign halted      = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH_OP;
      end else begin
         state <= state_next;
      end
   end

   // A new request is only started while the port is idle, so the cycle
   // carrying the ack never re-launches the same access.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      req_we     = 1'b0;
      req_addr   = pc;
      case (state)
         FETCH_OP: begin
            start = !mem_req;
            if (done) begin
               state_next = (mem_rdata[7:5] == OP_HLT) ? HALT : FETCH_ARG;
            end
         end
         FETCH_ARG: begin
            start = !mem_req;
            if (done) begin
               case (ir_op)
                  OP_STA:         state_next = WRITE;
                  OP_LDI, OP_BRZ: state_next = EXEC;
                  default:        state_next = READ_DATA;
               endcase
            end
         end
         READ_DATA: begin
            start    = !mem_req;
            req_addr = ADDR_W'(operand);
            if (done) state_next = EXEC;
         end
         WRITE: begin
            start    = !mem_req;
            req_we   = 1'b1;
            req_addr = ADDR_W'(operand);
            if (done) state_next = FETCH_OP;
         end
         EXEC:    state_next = FETCH_OP;
         HALT:    state_next = HALT;
         default: state_next = FETCH_OP;
      endcase
   end

   // PC stays on the operand byte through EXEC so BRZ sees it on alu_pc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         ir_op   <= '0;
         operand <= '0;
         acc     <= '0;
      end else begin
         case (state)
            FETCH_OP: begin
               if (done) begin
                  ir_op <= mem_rdata[7:5];
                  pc    <= pc + 1'b1;
               end
            end
            FETCH_ARG, READ_DATA: begin
               if (done) operand <= mem_rdata;
            end
            WRITE: begin
               if (done) pc <= pc + 1'b1;
            end
            EXEC: begin
               case (ir_op)
                  OP_ADD, OP_NAND, OP_SLT: begin
                     acc <= alu_result;
                     pc  <= pc + 1'b1;
                  end
                  OP_LDA, OP_LDI: begin
                     acc <= operand;
                     pc  <= pc + 1'b1;
                  end
                  OP_BRZ:  pc <= ADDR_W'(alu_result);
                  default: pc <= pc + 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
   logic retire;
   assign retire = (state == EXEC) ||
                   (state == WRITE && done) ||
                   (state == FETCH_OP && done && mem_rdata[7:5] == OP_HLT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (retire) begin
         retire_cnt <= retire_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_req, mem_we, mem_ack;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0] alu_control;
   logic [7:0] alu_acc, alu_data, alu_pc, alu_result;
   logic [7:0] acc_out;
   logic       halted;
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   always #5 clk = ~clk;

   cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .alu_control (alu_control),
      .alu_acc     (alu_acc),
      .alu_data    (alu_data),
      .alu_pc      (alu_pc),
      .alu_result  (alu_result),
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
      .retire_cnt  (retire_cnt),
`endif
      .acc_out     (acc_out),
      .halted      (halted)
   );

   // ---------------- memory model (program image + one write overlay) ----
   logic [7:0] mem [256];
   int         ack_delay;
   logic       hold_ack;
   int         wcnt;
   logic       wr_valid;
   logic [7:0] wr_addr, wr_data;
   int         n_wr, n_ack, cyc;
   logic [7:0] last_addr, first_addr;
   logic       pend, unstable, h_we;
   logic [7:0] h_addr, h_wdata;

   assign mem_ack   = mem_req && !hold_ack && (wcnt == ack_delay);
   assign mem_rdata = (wr_valid && mem_addr == wr_addr) ? wr_data : mem[mem_addr];

   // External ALU behaviour
   always_comb begin
      case (alu_control)
         2'b00:   alu_result = alu_acc + alu_data;
         2'b01:   alu_result = ~(alu_acc & alu_data);
         2'b10:   alu_result = (alu_acc == 8'h00) ? alu_data : alu_pc + 8'd1;
         default: alu_result = {7'd0, (alu_acc < alu_data)};
      endcase
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= 0; wr_valid <= 1'b0; wr_addr <= 8'h00; wr_data <= 8'h00;
         n_wr <= 0; n_ack <= 0; cyc <= 0; last_addr <= 8'h00; first_addr <= 8'h00;
         pend <= 1'b0; unstable <= 1'b0; h_we <= 1'b0; h_addr <= 8'h00; h_wdata <= 8'h00;
      end else begin
         cyc <= cyc + 1;
         wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
         if (mem_ack) begin
            n_ack     <= n_ack + 1;
            last_addr <= mem_addr;
            if (n_ack == 0) first_addr <= mem_addr;
            if (mem_we) begin
               wr_valid <= 1'b1; wr_addr <= mem_addr; wr_data <= mem_wdata;
               n_wr <= n_wr + 1;
            end
         end
         if (mem_req) begin
            if (pend) begin
               if (mem_we !== h_we || mem_addr !== h_addr || (mem_we && mem_wdata !== h_wdata))
                  unstable <= 1'b1;
            end else begin
               h_we <= mem_we; h_addr <= mem_addr; h_wdata <= mem_wdata;
            end
            pend <= !mem_ack;
         end else begin
            pend <= 1'b0;
         end
      end
   end

   // ACC change history (seen one cycle after each update)
   logic [7:0] acc_hist [8];
   int         n_hist;
   logic [7:0] acc_prev;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_hist <= 0; acc_prev <= 8'h00;
      end else if (acc_out != acc_prev) begin
         if (n_hist < 8) acc_hist[n_hist] <= acc_out;
         n_hist   <= n_hist + 1;
         acc_prev <= acc_out;
      end
   end

   // ---------------- checking -------------------------------------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
   endtask

   task automatic do_reset(input int dly);
      rst_n = 1'b0;
      ack_delay = dly;
      hold_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_halt(input string tag, input int budget, output int cycles);
      int k;
      k = 0;
      while (!halted && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
      cycles = cyc;
   endtask

   task automatic slt_case(input string tag, input logic [7:0] m, input logic [7:0] exp);
      int c;
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'h07; mem[2] = 8'h60; mem[3] = 8'h30; mem[4] = 8'hE0;
      mem[8'h30] = m;
      do_reset(0);
      run_to_halt(tag, 200, c);
      chk({tag, "_acc"}, {24'd0, acc_out}, {24'd0, exp});
      chk({tag, "_cycles"}, c, 32'd14);
   endtask

   initial begin
      int c;
      int k;
      rst_n = 1'b0;
      ack_delay = 0;
      hold_ack = 1'b0;
      clr_mem();

      // Reset state
      #1;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("rst_ctl", {30'd0, alu_control}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_acc", {24'd0, acc_out}, 32'd0);
      chk("rst_pc", {24'd0, alu_pc}, 32'd0);
      chk("rst_data", {24'd0, alu_data}, 32'd0);
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
      chk("rst_retire", {16'd0, retire_cnt}, 32'd0);
`endif

      // LDI 05; ADD [10]; HLT  with M[10]=03
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h10; mem[4] = 8'hF0;
      mem[8'h10] = 8'h03;
      do_reset(0);
      run_to_halt("add", 200, c);
      chk("add_cycles", c, 32'd14);
      chk("add_acc", {24'd0, acc_out}, 32'h08);
      chk("add_hist_n", n_hist, 32'd2);
      chk("add_hist0", {24'd0, acc_hist[0]}, 32'h05);
      chk("add_pc", {24'd0, alu_pc}, 32'h05);
      chk("add_acks", n_ack, 32'd6);
      chk("add_last", {24'd0, last_addr}, 32'h04);
      chk("add_req_idle", {31'd0, mem_req}, 32'd0);
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
      chk("add_retire", {16'd0, retire_cnt}, 32'd3);
`endif

      // BRZ taken: LDI 00; BRZ 20; M[20]=HLT
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'h00; mem[2] = 8'h40; mem[3] = 8'h20;
      mem[8'h20] = 8'hE0;
      do_reset(0);
      run_to_halt("brz_t", 200, c);
      chk("brz_t_cycles", c, 32'd12);
      chk("brz_t_last", {24'd0, last_addr}, 32'h20);
      chk("brz_t_pc", {24'd0, alu_pc}, 32'h21);

      // BRZ not taken: LDI 01; BRZ 20; falls through to 04
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'h01; mem[2] = 8'h40; mem[3] = 8'h20;
      mem[4] = 8'hE0; mem[8'h20] = 8'h00;
      do_reset(0);
      run_to_halt("brz_n", 200, c);
      chk("brz_n_last", {24'd0, last_addr}, 32'h04);
      chk("brz_n_pc", {24'd0, alu_pc}, 32'h05);
      chk("brz_n_acc", {24'd0, acc_out}, 32'h01);

      // SLT, unsigned
      slt_case("slt_lt", 8'h09, 8'h01);
      slt_case("slt_eq", 8'h07, 8'h00);
      slt_case("slt_gt", 8'h02, 8'h00);

      // STA with 3-cycle ack delay, then LDI 00 / LDA back
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'hAA; mem[2] = 8'hA0; mem[3] = 8'h40;
      mem[4] = 8'hC0; mem[5] = 8'h00; mem[6] = 8'h80; mem[7] = 8'h40; mem[8] = 8'hE0;
      do_reset(3);
      run_to_halt("sta", 600, c);
      chk("sta_nwr", n_wr, 32'd1);
      chk("sta_waddr", {24'd0, wr_addr}, 32'h40);
      chk("sta_wdata", {24'd0, wr_data}, 32'hAA);
      chk("sta_stable", {31'd0, unstable}, 32'd0);
      chk("sta_lda_acc", {24'd0, acc_out}, 32'hAA);
      chk("sta_hist_n", n_hist, 32'd3);

      // Wrap: jump to FE, LDI with operand at FF, next fetch at 00
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'h00; mem[2] = 8'h40; mem[3] = 8'hFE;
      mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'h5A;
      do_reset(0);
      k = 0;
      while (acc_out != 8'h5A && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("wrap_acc", {24'd0, acc_out}, 32'h5A);
      chk("wrap_arg_addr", {24'd0, last_addr}, 32'hFF);
      chk("wrap_pc", {24'd0, alu_pc}, 32'h00);
      k = 0;
      while (!mem_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("wrap_fetch_addr", {24'd0, mem_addr}, 32'h00);

      // Reset while a request is outstanding and ack is withheld
      clr_mem();
      mem[0] = 8'hC0; mem[1] = 8'h05; mem[2] = 8'hE0;
      do_reset(0);
      hold_ack = 1'b1;
      k = 0;
      while (!mem_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("abort_req_up", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_req", {31'd0, mem_req}, 32'd0);
      chk("abort_we", {31'd0, mem_we}, 32'd0);
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
      chk("abort_retire", {16'd0, retire_cnt}, 32'd0);
`endif
      hold_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      while (n_ack == 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("abort_first_addr", {24'd0, first_addr}, 32'h00);
      chk("abort_acc", {24'd0, acc_out}, 32'h00);
      run_to_halt("abort", 200, c);
      chk("abort_end_acc", {24'd0, acc_out}, 32'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
